seg7_scanner: RTL and testbench
===============================

# seg7_scanner

Downstream display stage for the single-cycle CPU board top: consumes the 32-bit register word selected by the board switches and time-multiplexes it as 8 hex digits onto a common-anode seven-segment display. It holds a shadow copy of the word, advances a refresh counter, rotates a one-hot digit select, and drives registered anode and segment lines. It replaces the 8-bit LED view of the low byte with a full-word view.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays lit; legal range ≥ 2.
- DIGITS, 8: number of hex digits; fixed at 8 in this revision.
- clock  in  1  board clock (undivided).
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- value  in  32  word to display (register-file display output).
- load  in  1  capture value into the shadow register on this edge.
- blank_lz  in  1  when 1, suppress leading zero digits.
- anode  out  8  digit enables, active-low, one-hot; bit i = digit i; digit 0 = value[3:0].
- segment  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame  out  1  one-cycle pulse when digit 7's slot ends.

## Operation
- shadow: 32-bit register. Reset → 0. load=1 → shadow ← value; otherwise hold.
- cnt: counts 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV). Wraps to 0 at REFRESH_DIV-1. tick = (cnt == REFRESH_DIV-1).
- idx: 3-bit digit index. Reset → 0. On tick, idx ← idx+1 mod 8.
- frame: registered; 1 for exactly one cycle, on the cycle after the tick where idx goes 7→0.
- nibble = shadow[4*idx +: 4]; decoded via hex_to_seg7. Codes: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110. All 16 codes are required.
- Leading-zero blanking: msd = index of the highest nonzero nibble of shadow (0 if shadow==0).
  - blank_lz=1 and idx > msd → anode all 1s, segment 7'h7F, dp 1.
  - Digit 0 is never blanked, so 0 displays as a single "0".
- dp is lit (0) only when idx==4 and digit 4 is not blanked. It marks the halfword boundary.
- Otherwise anode = ~(8'b1 << idx).
- Reset has priority over load and tick on the same edge.

## Timing
- Reset values: anode=8'hFF, segment=7'h7F, dp=1, frame=0, shadow=0, cnt=0, idx=0.
- All outputs are registered and reflect idx/shadow from the previous cycle.
- After reset release, the first edge drives digit 0 of shadow=0: anode=8'hFE, segment=1000000.
- load at edge t → shadow updated at t → outputs reflect the new nibble from edge t+1.
- Each digit is lit for exactly REFRESH_DIV cycles; one full frame is 8·REFRESH_DIV cycles.
- Changing blank_lz takes effect on the next edge with no idx disturbance.
- Reset mid-frame: the next edge returns all state to reset values; the partial frame is discarded and no frame pulse is emitted.
- Anode is never multi-hot, including across idx change and reset: a single registered one-hot word is required.

## Structure
- Package seg7_pkg:
  - DIGITS constant.
  - Active-low segment code constants for the 16 hex values.
  - BLANK_SEG = 7'h7F and ANODE_OFF = 8'hFF.
- Sub-module hex_to_seg7 (combinational, 4-bit in, 7-bit out) for the decoder.
- The leading-zero priority encoder stays inline.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset, then hold reset for 3 cycles → anode=FF, segment=7F, dp=1, frame=0 throughout. After release → anode=FE, segment=1000000.
- load value=32'h1234ABCD, blank_lz=0 → digits 0..7 show D,C,B,A,4,3,2,1. Each is held 4 cycles; dp=0 only while anode=EF. frame pulses once per 32 cycles.
- load 32'h000000F0, blank_lz=1:
  - idx 0 → "0".
  - idx 1 → F (0001110).
  - idx 2..7 → anode=FF, segment=7F.
- load 0, blank_lz=1 → only digit 0 is lit, showing 1000000. dp stays 1 all frame.
- load pulsed with value 32'h8 while idx=0 and old shadow=0 → segment changes from 1000000 to 0000000 exactly one edge after the load edge; idx and cnt are unaffected.
- Assert reset with load=1 mid-frame at idx=5 → next edge gives shadow=0, idx=0, cnt=0, anode=FF, and no frame pulse. Scanning then restarts from digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner.
// Segment codes are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int DIGITS = 8;
    localparam int IDX_W  = $clog2(DIGITS);

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0]        BLANK_SEG = 7'h7F;
    localparam logic [DIGITS-1:0] ANODE_OFF = 8'hFF;

endpackage

// File: rtl/seg7_scanner_if.sv
// Display bus between the CPU board top and the scanner.
//   value/load/blank_lz : word to show, capture strobe, leading-zero blanking
//   anode/segment/dp    : active-low display drive
//   frame               : one-cycle pulse at the end of each full scan
interface seg7_scanner_if;
    import seg7_pkg::*;

    logic [31:0]       value;
    logic              load;
    logic              blank_lz;
    logic [DIGITS-1:0] anode;
    logic [6:0]        segment;
    logic              dp;
    logic              frame;

    modport master (
        output value, load, blank_lz,
        input  anode, segment, dp, frame
    );

    modport slave (
        input  value, load, blank_lz,
        output anode, segment, dp, frame
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble_i  : 4-bit hex value
//   segment_o : {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] segment_o
);
    always_comb begin
        segment_o = BLANK_SEG;
        case (nibble_i)
            4'h0: segment_o = SEG_0;
            4'h1: segment_o = SEG_1;
            4'h2: segment_o = SEG_2;
            4'h3: segment_o = SEG_3;
            4'h4: segment_o = SEG_4;
            4'h5: segment_o = SEG_5;
            4'h6: segment_o = SEG_6;
            4'h7: segment_o = SEG_7;
            4'h8: segment_o = SEG_8;
            4'h9: segment_o = SEG_9;
            4'hA: segment_o = SEG_A;
            4'hB: segment_o = SEG_B;
            4'hC: segment_o = SEG_C;
            4'hD: segment_o = SEG_D;
            4'hE: segment_o = SEG_E;
            4'hF: segment_o = SEG_F;
            default: segment_o = BLANK_SEG;
        endcase
    end
endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed 8-digit hex display driver for a common-anode display.
//   clock, reset : board clock, synchronous active-high reset
//   bus          : slave side of seg7_scanner_if (word in, display drive out)
// REFRESH_DIV is the number of clocks each digit stays lit (>= 2).
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic           clock,
    input  logic           reset,
    seg7_scanner_if.slave  bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [31:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic [6:0]        segment_q, segment_d;
    logic              dp_q, dp_d;
    logic              frame_q, frame_d;

    logic              tick;
    logic [IDX_W-1:0]  msd;
    logic              blank;
    logic [3:0]        nibble;
    logic [6:0]        seg_code;

    assign tick   = (cnt_q == CNT_LAST);
    assign nibble = shadow_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble_i  (nibble),
        .segment_o (seg_code)
    );

    // Highest nonzero nibble; stays 0 for an all-zero word so digit 0 is
    // never blanked.
    always_comb begin
        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (shadow_q[4*i +: 4] != 4'h0) begin
                msd = IDX_W'(i);
            end
        end
    end

    assign blank = bus.blank_lz && (idx_q > msd);

    always_comb begin
        shadow_d = bus.load ? bus.value : shadow_q;
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = tick ? idx_q + 1'b1 : idx_q;
        // Frame pulse lands on the cycle after digit 7's last tick.
        frame_d  = tick && (idx_q == IDX_W'(DIGITS - 1));

        if (blank) begin
            anode_d   = ANODE_OFF;
            segment_d = BLANK_SEG;
            dp_d      = 1'b1;
        end else begin
            anode_d   = ~(DIGITS'(1) << idx_q);
            segment_d = seg_code;
            // Lit decimal point marks the halfword boundary.
            dp_d      = (idx_q != IDX_W'(4));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q  <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            anode_q   <= ANODE_OFF;
            segment_q <= BLANK_SEG;
            dp_q      <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            anode_q   <= anode_d;
            segment_q <= segment_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.anode   = anode_q;
    assign bus.segment = segment_q;
    assign bus.dp      = dp_q;
    assign bus.frame   = frame_q;
endmodule

// File: tb/tb_seg7_scanner.sv
// Bench for seg7_scanner with REFRESH_DIV=4: every clock the expected display
// word is pushed to a scoreboard queue and popped against the DUT outputs.
module tb_seg7_scanner;

    localparam int DIV = 4;

    typedef struct packed {
        logic [7:0] anode;
        logic [6:0] segment;
        logic       dp;
        logic       frame;
    } exp_t;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    seg7_scanner_if bus ();

    seg7_scanner #(.REFRESH_DIV(DIV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    logic [31:0] m_shadow = '0;
    int          m_cnt = 0;
    int          m_idx = 0;

    logic [7:0] o_anode;
    logic [6:0] o_segment;
    logic       o_dp;
    logic       o_frame;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict outputs for this edge, compare after it.
    task automatic step(input logic r, input logic ld, input logic [31:0] v, input logic bl);
        exp_t e;
        exp_t got;
        int   msd;
        reset        = r;
        bus.load     = ld;
        bus.value    = v;
        bus.blank_lz = bl;

        if (r) begin
            e = '{anode: 8'hFF, segment: 7'h7F, dp: 1'b1, frame: 1'b0};
            m_shadow = '0;
            m_cnt = 0;
            m_idx = 0;
        end else begin
            msd = 0;
            for (int i = 7; i >= 0; i--) begin
                if (msd == 0 && ((m_shadow >> (4*i)) & 32'hF) != 0) msd = i;
            end
            if (bl && m_idx > msd) begin
                e.anode = 8'hFF;
                e.segment = 7'h7F;
                e.dp = 1'b1;
            end else begin
                e.anode = 8'hFF;
                e.anode[m_idx] = 1'b0;
                e.segment = SEG_TBL[(m_shadow >> (4*m_idx)) & 32'hF];
                e.dp = (m_idx == 4) ? 1'b0 : 1'b1;
            end
            e.frame = (m_cnt == DIV-1) && (m_idx == 7);
            if (ld) m_shadow = v;
            if (m_cnt == DIV-1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_cnt++;
            end
        end
        sb_q.push_back(e);

        @(posedge clock);
        #1;
        o_anode   = bus.anode;
        o_segment = bus.segment;
        o_dp      = bus.dp;
        o_frame   = bus.frame;
        got = '{anode: o_anode, segment: o_segment, dp: o_dp, frame: o_frame};
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            checks++;
            assert (got === e) else begin
                errors++;
                $error("FAIL scan observed=anode %h seg %b dp %b frame %b expected=anode %h seg %b dp %b frame %b",
                       got.anode, got.segment, got.dp, got.frame,
                       e.anode, e.segment, e.dp, e.frame);
            end
        end
    endtask

    initial begin
        int n_frame;
        int n_dp;
        int n_off;
        int n_lit;
        bus.value    = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;

        // Reset held for several cycles.
        step(1, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0);
        check8("reset_anode", o_anode, 8'hFF);
        check8("reset_segment", {1'b0, o_segment}, 8'h7F);
        check8("reset_frame", {7'b0, o_frame}, 8'h00);

        // First edge after release shows digit 0 of a zero word.
        step(0, 0, 32'h0, 0);
        check8("release_anode", o_anode, 8'hFE);
        check8("release_segment", {1'b0, o_segment}, {1'b0, 7'b1000000});

        // Full word, no blanking.
        step(0, 1, 32'h1234ABCD, 0);
        step(0, 0, 32'h0, 0);
        n_frame = 0; n_dp = 0;
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 32'h0, 0);
            if (o_frame) n_frame++;
            if (!o_dp) begin
                n_dp++;
                check8("dp_anode", o_anode, 8'hEF);
            end
        end
        check_int("frame_per_32", n_frame, 1);
        check_int("dp_cycles", n_dp, 4);

        // Leading-zero blanking of 0x000000F0.
        step(0, 1, 32'h000000F0, 1);
        step(0, 0, 32'h0, 1);
        n_off = 0;
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 32'h0, 1);
            if (o_anode == 8'hFF) n_off++;
            if (o_anode == 8'hFD) check8("digit1_F", {1'b0, o_segment}, {1'b0, 7'b0001110});
        end
        check_int("blank_cycles_F0", n_off, 24);

        // Zero word with blanking: single "0" on digit 0, no dp.
        step(0, 1, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        n_lit = 0; n_dp = 0;
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 32'h0, 1);
            if (o_anode != 8'hFF) begin
                n_lit++;
                check8("zero_anode", o_anode, 8'hFE);
            end
            if (!o_dp) n_dp++;
        end
        check_int("zero_lit_cycles", n_lit, 4);
        check_int("zero_dp_cycles", n_dp, 0);

        // Load while digit 0 is showing the old zero word.
        for (int i = 0; i < 40 && !(m_idx == 0 && m_cnt == 1); i++) step(0, 0, 32'h0, 1);
        check_int("align_idx0", m_idx, 0);
        step(0, 1, 32'h8, 1);
        check8("load_edge_seg", {1'b0, o_segment}, {1'b0, 7'b1000000});
        step(0, 0, 32'h0, 1);
        check8("load_next_seg", {1'b0, o_segment}, {1'b0, 7'b0000000});
        check8("load_next_anode", o_anode, 8'hFE);
        for (int i = 0; i < 40; i++) step(0, 0, 32'h0, 1);

        // Reload a full word, then reset mid-frame with load asserted.
        step(0, 1, 32'h87654321, 0);
        for (int i = 0; i < 40 && !(m_idx == 5 && m_cnt == 1); i++) step(0, 0, 32'h0, 0);
        check_int("align_idx5", m_idx, 5);
        step(1, 1, 32'hDEADBEEF, 0);
        check8("midreset_anode", o_anode, 8'hFF);
        check8("midreset_frame", {7'b0, o_frame}, 8'h00);
        step(0, 0, 32'h0, 0);
        check8("restart_anode", o_anode, 8'hFE);
        check8("restart_segment", {1'b0, o_segment}, {1'b0, 7'b1000000});
        n_frame = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 32'h0, 0);
            if (o_frame) n_frame++;
        end
        check_int("restart_no_early_frame", n_frame, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
